// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - UART receiver state encoding and parameter ranges; UART_RX_PARITY_EN adds the PARITY state
package uart_rx_pkg;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;

    // Counter widths cover the widest legal configuration
    localparam int TICK_CNT_W = $clog2(OVERSAMPLE_MAX);
    localparam int BIT_IDX_W  = $clog2(DATA_BITS_MAX);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_tickgen.sv
// rtl/uart_rx_tickgen.sv - free-running CLK_DIV divider producing the oversample tick, restartable
module uart_rx_tickgen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with valid/ready output; UART_RX_PARITY_EN enables parity checking
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [TICK_CNT_W-1:0] TICK_MID  = TICK_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_IDX_W-1:0]  BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic                  STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_t               state;
    logic                    rx_meta, rxs, rxs_d;
    logic                    tick, start_edge, bit_mid;
    logic [TICK_CNT_W-1:0]   tick_cnt;
    logic [BIT_IDX_W-1:0]    bit_idx;
    logic                    stop_cnt;
    logic [DATA_BITS-1:0]    shift;
    logic                    fe_acc;
    logic                    done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // A held-low line never produces a fresh falling edge, so a break yields a single frame
    assign start_edge = rxs_d & ~rxs;
    assign bit_mid    = tick && (tick_cnt == TICK_LAST);
    assign busy       = (state != ST_IDLE);

    uart_rx_tickgen #(
        .CLK_DIV (CLK_DIV)
    ) u_tickgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart ((state == ST_IDLE) && start_edge),
        .tick    (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic pe_acc;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            fe_acc   <= 1'b0;
            done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_acc   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && state != ST_START && tick) begin
                tick_cnt <= bit_mid ? '0 : tick_cnt + TICK_CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            stop_cnt <= 1'b0;
                            fe_acc   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            pe_acc   <= 1'b0;
`endif
                            state    <= rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_mid) begin
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_mid) begin
                        pe_acc <= rxs ^ (^shift) ^ PARITY_ODD[0];
                        state  <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_mid) begin
                        fe_acc <= fe_acc | ~rxs;
                        if (stop_cnt == STOP_LAST) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Results are taken from shift/fe_acc the cycle after the last stop sample; both stay stable in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (done && valid && !ready) begin
                overrun <= 1'b1;
            end else if (done) begin
                data      <= shift;
                valid     <= 1'b1;
                frame_err <= fe_acc;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= done && !(valid && !ready) && pe_acc;
        end
    end
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = 1'(PARITY_ODD);
    assign parity_err        = 1'b0;
`endif

endmodule
